// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one N-bit register among NREQ requesters.
// Latency: grant one edge after req is sampled, write/done on the following edge.
// Backpressure: requesters hold req until done or abandon; losers wait in IDLE order.
module shared_reg_arbiter #(
  parameter int N    = 64,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ*N-1:0]         wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [N-1:0]              q,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int SW = $clog2(NREQ);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   ptr;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [SW-1:0]   pick;
  logic [N-1:0]    lane_sel;
  int              p;

  function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] i);
    if (i == SW'(NREQ - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // A requester whose done is still high has not had a chance to drop req yet,
  // so it is kept out of the next arbitration round.
  assign elig     = req & ~done;
  assign lane_sel = wdata[sel*N +: N];

  // Rotating-priority search: first eligible index starting at ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    p     = 0;
    for (int off = 0; off < NREQ; off++) begin
      p = int'(ptr) + off;
      if (p >= NREQ) begin
        p = p - NREQ;
      end
      if (!found && elig[p]) begin
        found = 1'b1;
        pick  = p[SW-1:0];
      end
    end
  end

  // Two-state control plus the shared register; every output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      done  <= '0;
      q     <= '0;
      owner <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (found) begin
            sel   <= pick;
            gnt   <= onehot(pick);
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            // Winner walked away before writing: release without a write.
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr(sel);
            state <= IDLE;
          end else begin
            q     <= lane_sel;
            owner <= sel;
            done  <= onehot(sel);
            if (!lock[sel]) begin
              gnt   <= '0;
              busy  <= 1'b0;
              ptr   <= next_ptr(sel);
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: vector table, directed corner
// sequences, then random traffic against a rule-level reference model.
module tb_shared_reg_arbiter;

  localparam int N    = 64;
  localparam int NREQ = 4;

  logic           clk;
  logic           reset;
  logic [3:0]     req;
  logic [3:0]     lock;
  logic [255:0]   wdata;
  logic [3:0]     gnt;
  logic [3:0]     done;
  logic [63:0]    q;
  logic [1:0]     owner;
  logic           busy;

  shared_reg_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .done  (done),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic [63:0] qq, input logic [1:0] o, input logic b);
    chk({tag, " gnt"},   128'(gnt),   128'(g));
    chk({tag, " done"},  128'(done),  128'(d));
    chk({tag, " q"},     128'(q),     128'(qq));
    chk({tag, " owner"}, 128'(owner), 128'(o));
    chk({tag, " busy"},  128'(busy),  128'(b));
  endtask

  // gnt must never have more than one bit set.
  always @(negedge clk) begin
    if (reset) begin
      n_cmp++;
      if (!$onehot0(gnt)) begin
        n_bad++;
        $display("FAIL gnt_onehot: got %b required at most one bit", gnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] lanes(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy;
  int          m_sel;
  int          m_ptr;
  logic [63:0] m_q;
  int          m_owner;
  logic [3:0]  m_gnt;
  logic [3:0]  m_done;

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_q = '0; m_owner = 0; m_gnt = '0; m_done = '0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic [255:0] w);
    logic [3:0] e;
    bit         got;
    if (!m_busy) begin
      e      = r & ~m_done;
      m_done = '0;
      got    = 0;
      for (int off = 0; off < NREQ; off++) begin
        int idx;
        idx = (m_ptr + off) % NREQ;
        if (!got && e[idx]) begin
          got    = 1;
          m_sel  = idx;
        end
      end
      if (got) begin
        m_busy = 1;
        m_gnt  = 4'(1 << m_sel);
      end
    end else if (!r[m_sel]) begin
      m_busy = 0;
      m_gnt  = '0;
      m_done = '0;
      m_ptr  = (m_sel + 1) % NREQ;
    end else begin
      m_q     = w[m_sel*64 +: 64];
      m_owner = m_sel;
      m_done  = 4'(1 << m_sel);
      if (!l[m_sel]) begin
        m_busy = 0;
        m_gnt  = '0;
        m_ptr  = (m_sel + 1) % NREQ;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]   req;
    logic [3:0]   lock;
    logic [255:0] wdata;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic [63:0]  q;
    logic [1:0]   owner;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  logic [255:0] rr_l;
  logic [255:0] sg_l;
  logic [3:0]   r;
  logic [3:0]   l;
  logic [255:0] w;

  initial begin
    rr_l = lanes(64'h10, 64'h11, 64'h12, 64'h13);
    sg_l = lanes(64'h10, 64'h11, 64'hDEAD_BEEF_0000_0002, 64'h13);
    // Round robin with all requesting: order 0,1,2,3,0 at 2-cycle spacing.
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h1, 4'h0, 64'h00, 2'd0, 1'b1});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h0, 4'h1, 64'h10, 2'd0, 1'b0});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h2, 4'h0, 64'h10, 2'd0, 1'b1});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h0, 4'h2, 64'h11, 2'd1, 1'b0});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h4, 4'h0, 64'h11, 2'd1, 1'b1});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h0, 4'h4, 64'h12, 2'd2, 1'b0});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h8, 4'h0, 64'h12, 2'd2, 1'b1});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h0, 4'h8, 64'h13, 2'd3, 1'b0});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h1, 4'h0, 64'h13, 2'd3, 1'b1});
    tbl.push_back('{4'hF, 4'h0, rr_l, 4'h0, 4'h1, 64'h10, 2'd0, 1'b0});
    tbl.push_back('{4'h0, 4'h0, rr_l, 4'h0, 4'h0, 64'h10, 2'd0, 1'b0});
    // Single request from 2; no re-grant while its done is high.
    tbl.push_back('{4'h4, 4'h0, sg_l, 4'h4, 4'h0, 64'h10, 2'd0, 1'b1});
    tbl.push_back('{4'h4, 4'h0, sg_l, 4'h0, 4'h4, 64'hDEAD_BEEF_0000_0002, 2'd2, 1'b0});
    tbl.push_back('{4'h4, 4'h0, sg_l, 4'h0, 4'h0, 64'hDEAD_BEEF_0000_0002, 2'd2, 1'b0});
    tbl.push_back('{4'h0, 4'h0, sg_l, 4'h0, 4'h0, 64'hDEAD_BEEF_0000_0002, 2'd2, 1'b0});
  end

  initial begin
    reset = 1'b0;
    req   = 4'hF;
    lock  = 4'h0;
    wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #1;
    chk_all("reset_async", 4'h0, 4'h0, 64'h0, 2'd0, 1'b0);
    repeat (3) tick();
    chk_all("reset_held", 4'h0, 4'h0, 64'h0, 2'd0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      req   = tbl[i].req;
      lock  = tbl[i].lock;
      wdata = tbl[i].wdata;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].done, tbl[i].q, tbl[i].owner, tbl[i].busy);
    end

    // Move ptr to 1 via a transfer from requester 0 (ptr was 3).
    req = 4'h1; tick(); chk_all("pre0_gnt", 4'h1, 4'h0, 64'hDEAD_BEEF_0000_0002, 2'd2, 1'b1);
    tick(); chk_all("pre0_wr", 4'h0, 4'h1, 64'h10, 2'd0, 1'b0);
    req = 4'h0; tick(); chk_all("pre0_idle", 4'h0, 4'h0, 64'h10, 2'd0, 1'b0);

    // Locked burst from 1 while 3 waits.
    req = 4'hA; lock = 4'h2; wdata = lanes(64'h0, 64'hA, 64'h0, 64'h33);
    tick(); chk_all("lk_gnt", 4'h2, 4'h0, 64'h10, 2'd0, 1'b1);
    tick(); chk_all("lk_a", 4'h2, 4'h2, 64'hA, 2'd1, 1'b1);
    wdata = lanes(64'h0, 64'hB, 64'h0, 64'h33);
    tick(); chk_all("lk_b", 4'h2, 4'h2, 64'hB, 2'd1, 1'b1);
    wdata = lanes(64'h0, 64'hC, 64'h0, 64'h33); lock = 4'h0;
    tick(); chk_all("lk_c", 4'h0, 4'h2, 64'hC, 2'd1, 1'b0);
    req = 4'h8;
    tick(); chk_all("lk_next3", 4'h8, 4'h0, 64'hC, 2'd1, 1'b1);
    tick(); chk_all("lk_wr3", 4'h0, 4'h8, 64'h33, 2'd3, 1'b0);
    req = 4'h0;

    // Abandon by requester 2; ptr must land on 3.
    req = 4'h4; tick(); chk_all("ab_gnt", 4'h4, 4'h0, 64'h33, 2'd3, 1'b1);
    req = 4'h0; tick(); chk_all("ab_drop", 4'h0, 4'h0, 64'h33, 2'd3, 1'b0);
    req = 4'hF; wdata = rr_l;
    tick(); chk_all("ab_ptr3", 4'h8, 4'h0, 64'h33, 2'd3, 1'b1);
    tick(); chk_all("ab_wr3", 4'h0, 4'h8, 64'h13, 2'd3, 1'b0);
    req = 4'h0; tick();

    // Move ptr to 2, then lock requester 2 and reset between edges.
    req = 4'h2; tick(); tick(); req = 4'h0; tick();
    req = 4'h4; lock = 4'h4; wdata = lanes(64'h0, 64'h0, 64'h55, 64'h0);
    tick(); chk_all("ar_gnt", 4'h4, 4'h0, 64'h11, 2'd1, 1'b1);
    tick(); chk_all("ar_wr", 4'h4, 4'h4, 64'h55, 2'd2, 1'b1);
    #2; reset = 1'b0; #1;
    chk_all("ar_clear", 4'h0, 4'h0, 64'h0, 2'd0, 1'b0);
    req = 4'h0; lock = 4'h0;
    tick(); tick();
    reset = 1'b1;
    req = 4'h9;
    tick(); chk_all("ar_ptr0", 4'h1, 4'h0, 64'h0, 2'd0, 1'b1);

    // Random traffic against the reference model.
    req = 4'h0; lock = 4'h0;
    reset = 1'b0; tick(); reset = 1'b1;
    model_reset();
    r = 4'h0; l = 4'h0; w = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      l = 4'($urandom);
      if ($urandom_range(1) == 0) begin
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
      end
      req = r; lock = l; wdata = w;
      @(posedge clk);
      model_step(r, l, w);
      #1;
      chk_all($sformatf("rnd%0d", c), m_gnt, m_done, m_q, 2'(m_owner), m_busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
